// File: rtl/ifetch_mem_responder.sv
// Instruction-fetch memory responder: byte array with programmable wait states,
// a single-entry sequential prefetch buffer and a loader write port.
module ifetch_mem_responder #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned PREFETCH    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_ack,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              pf_hit
);

  localparam int unsigned Depth    = 1 << ADDR_W;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StPref} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic [DATA_W-1:0] pf_data_q, pf_data_d;
  logic              pf_valid_q, pf_valid_d;

  logic [DATA_W-1:0] mem_q [Depth];

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ld_hits_pf;

  // Program array: loader writes land regardless of FSM state or reset.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // Array read port with write-first bypass so a same-edge loader write wins.
  always_comb begin
    rd_addr    = (state_q == StPref) ? pf_addr_q : addr_q;
    rd_data    = (ld_we && (ld_addr == rd_addr)) ? ld_data : mem_q[rd_addr];
    ld_hits_pf = ld_we && (ld_addr == pf_addr_q);
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      hit_q      <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      pf_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hit_q      <= hit_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      pf_valid_q <= pf_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hit_d      = hit_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;

    // A loader write to the buffered address makes the buffered byte stale.
    if (ld_hits_pf) begin
      pf_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (mem_rd_en) begin
          addr_d = mem_addr;
          if (pf_valid_q && !ld_hits_pf && (pf_addr_q == mem_addr)) begin
            data_d  = pf_data_q;
            hit_d   = 1'b1;
            state_d = StAck;
          end else begin
            cnt_d   = WaitInit;
            hit_d   = 1'b0;
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (!mem_rd_en) begin
          // Fetch unit withdrew the request: abandon without an ack.
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          data_d  = rd_data;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StAck: begin
        if (PREFETCH != 0) begin
          pf_addr_d  = addr_q + ADDR_W'(1);
          pf_valid_d = 1'b0;
          cnt_d      = WaitInit;
          state_d    = StPref;
        end else begin
          state_d = StIdle;
        end
      end

      StPref: begin
        if (mem_rd_en && (mem_addr != pf_addr_q)) begin
          // Non-sequential demand: drop the prefetch and start a full miss.
          pf_valid_d = 1'b0;
          addr_d     = mem_addr;
          hit_d      = 1'b0;
          cnt_d      = WaitInit;
          state_d    = StWait;
        end else if (ld_hits_pf) begin
          cnt_d = WaitInit;
        end else if (cnt_q <= 4'd1) begin
          cnt_d      = '0;
          pf_data_d  = rd_data;
          pf_valid_d = 1'b1;
          if (mem_rd_en) begin
            // Matching demand arrived mid-prefetch: serve it as a buffer hit.
            addr_d  = pf_addr_q;
            data_d  = rd_data;
            hit_d   = 1'b1;
            state_d = StAck;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs are only non-zero during the single ACK cycle.
  always_comb begin
    mem_ack  = (state_q == StAck);
    mem_data = mem_ack ? data_q : '0;
    pf_hit   = mem_ack && hit_q;
  end

endmodule

// File: doc/ifetch_mem_responder.md
Name: ifetch_mem_responder

Overview:
Memory-side responder for the instruction-fetch read port. It accepts `mem_addr`/`mem_rd_en` requests from the instruction fetch unit and returns one opcode byte with a one-cycle `mem_ack` pulse. Program bytes are held in an internal byte array with programmable wait states. A single-entry sequential prefetch buffer gives linear code single-cycle fetches. A loader write port fills the array before tasks run.

Parameters:
- ADDR_W, 15, request/loader address width.
- DATA_W, 8, byte width.
- WAIT_STATES, 2, array access cycles for a miss (1..15).
- PREFETCH, 1, 1 enables the sequential prefetch buffer; 0 makes every access a miss.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous reset, active-low.
- mem_addr  input  ADDR_W  fetch address, sampled with mem_rd_en.
- mem_rd_en  input  1  read request; held by fetch unit until ack seen.
- mem_data  output  DATA_W  returned byte, valid only while mem_ack=1.
- mem_ack  output  1  one-cycle completion pulse.
- ld_we  input  1  loader byte write strobe.
- ld_addr  input  ADDR_W  loader address.
- ld_data  input  DATA_W  loader byte.
- pf_hit  output  1  one-cycle pulse coincident with mem_ack when served from prefetch buffer.

Behaviour:
- Reset (reset=0 at an edge): state IDLE, mem_ack=0, mem_data=0, pf_hit=0, prefetch buffer invalid, wait counter 0. Array contents are not cleared. Reset mid-access aborts it; no ack is issued.
- States: IDLE, WAIT, ACK, PREF.
- IDLE, mem_rd_en=1 at edge E0:
  - Buffer valid and pf_addr==mem_addr: go to ACK. mem_ack and pf_hit are high in the cycle after E0.
  - Otherwise: latch the address, load counter=WAIT_STATES, go to WAIT.
- WAIT: counter decrements each edge. At the edge where it reaches 0, read the array into mem_data and go to ACK. Miss mem_ack is high in the cycle after edge E0+WAIT_STATES.
- ACK: exactly one cycle; mem_data is held. Next state is PREF if PREFETCH=1, else IDLE. mem_rd_en is ignored in ACK: the fetch unit drops it at the edge that ends ACK.
- PREF:
  - Sets pf_addr=(served addr+1) mod 2^ADDR_W, so 7FFF wraps to 0000.
  - Counts WAIT_STATES cycles, then captures the byte, sets buffer valid and returns to IDLE.
  - A request during PREF whose address matches pf_addr converts the prefetch into the demand access: ack the cycle after the prefetch completes, with pf_hit=1.
  - A non-matching request aborts the prefetch, invalidates the buffer and starts a full miss from that edge.
- mem_rd_en dropped during WAIT: abort, return to IDLE, no ack, buffer unchanged.
- Loader:
  - ld_we writes the array at the edge regardless of state.
  - A write to pf_addr while the buffer is valid or PREF is in flight invalidates the buffer.
  - An in-flight PREF restarts its count.
  - A write to the address of an in-flight miss in the same edge the array is read returns the new ld_data (write-first).
- mem_data returns to 0 outside ACK.
- At most one outstanding request; no queueing.

Test Plan:
- Miss latency: load 0x3000=0x5A, reset, wait 3 cycles, then assert mem_rd_en with mem_addr=0x3000 at edge E0 -> mem_ack=1 and mem_data=0x5A only in the cycle after E0+2; pf_hit=0; ack width exactly 1 cycle.
- Sequential hit: load 0x3001=0xC3; after the previous ack, wait 3 idle cycles, request 0x3001 -> ack the cycle after the request edge, mem_data=0xC3, pf_hit=1.
- Wrap and in-flight match: load 0x7FFF=0x11 and 0x0000=0x22. Read 0x7FFF (miss). Immediately request 0x0000 while in PREF -> data 0x22, pf_hit=1, ack right after prefetch completes.
- Non-sequential abort: after reading 0x3000, request 0x1234 (loaded 0x99) during PREF -> full miss latency, data 0x99, pf_hit=0.
- Loader invalidation: after buffer is valid for 0x3001, write ld_addr=0x3001, ld_data=0xEE, then request 0x3001 -> miss latency, data 0xEE, pf_hit=0.
- Abort and reset: drop mem_rd_en in WAIT -> no ack ever. Then assert reset=0 for one edge during a second WAIT -> no ack, outputs 0, and the next request to 0x3000 is a miss returning 0x5A.
